mac_feeder: RTL and testbench

MAC_FEEDER -- requirements
Module: mac_feeder

---
 rtl/mac_feeder_if.sv | 22 ++
 rtl/mac_feeder.sv | 100 ++++++++++
 tb/tb_mac_feeder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_feeder_if.sv
// Byte-stream input and operand-pair output bundle for the mac_feeder.
interface mac_feeder_if;
  localparam int unsigned DW = 8;

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_valid;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, a, b, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, a, b, out_valid
  );
endinterface

// File: rtl/mac_feeder.sv
// Pairs an interleaved a/b byte stream into operand pairs, buffers them in a
// small FIFO and issues one pair per cycle to the mac stage (zeros when idle).
module mac_feeder #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  mac_feeder_if.slave   bus,
  output logic [CW-1:0] count,
  output logic          phase
);
  localparam int unsigned DW = 8;
  localparam int unsigned PW = $clog2(DEPTH);

  logic [DW-1:0]   a_hold;
  logic [2*DW-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic            valid_q;

  logic ready_c;
  logic accept_c;
  logic push_c;
  logic pop_c;

  // Handshake and FIFO control decoded from current state
  always_comb begin
    ready_c  = ~phase | (count < CW'(DEPTH));
    accept_c = bus.in_valid & ready_c & ~flush;
    push_c   = accept_c & phase;
    pop_c    = bus.out_ready & (count != '0) & ~flush;
  end

  assign bus.in_ready  = ready_c;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.out_valid = valid_q;

  // Pair storage; contents are don't-care outside the valid window
  always_ff @(posedge clk) begin
    if (!reset && push_c) begin
      mem[wr_ptr] <= {a_hold, bus.in_data};
    end
  end

  // Byte phase, a-operand holding register and FIFO pointers/occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      phase  <= 1'b0;
      a_hold <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      phase  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept_c) begin
        phase <= ~phase;
        if (!phase) begin
          a_hold <= bus.in_data;
        end
      end
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Operand outputs: head pair on a pop, zeros otherwise so the mac adds nothing
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else if (pop_c) begin
      a_q     <= mem[rd_ptr][2*DW-1:DW];
      b_q     <= mem[rd_ptr][DW-1:0];
      valid_q <= 1'b1;
    end else begin
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder: queue-based reference model compared every
// cycle, plus hand-computed literal expectations at key points.
module tb_mac_feeder;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          flush;
  logic [CW-1:0] count;
  logic          phase;

  mac_feeder_if bus ();

  mac_feeder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .count (count),
    .phase (phase)
  );

  int vectors;
  int miscompares;

  // Reference model state
  logic [15:0] mq[$];
  logic        m_phase;
  logic [7:0]  m_hold;
  logic [7:0]  m_a;
  logic [7:0]  m_b;
  logic        m_v;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // Model: pairs bytes, queues pairs, pops one per edge when permitted
  initial begin
    mq.delete();
    m_phase = 1'b0; m_hold = '0; m_a = '0; m_b = '0; m_v = 1'b0;
    forever begin
      @(posedge clk);
      if (reset || flush) begin
        mq.delete();
        m_phase = 1'b0;
        if (reset) m_hold = '0;
        m_a = '0; m_b = '0; m_v = 1'b0;
      end else begin
        automatic bit rdy = !m_phase || (mq.size() < DEPTH);
        if (bus.out_ready && mq.size() > 0) begin
          automatic logic [15:0] p = mq.pop_front();
          m_a = p[15:8]; m_b = p[7:0]; m_v = 1'b1;
        end else begin
          m_a = '0; m_b = '0; m_v = 1'b0;
        end
        if (bus.in_valid && rdy) begin
          if (!m_phase) begin
            m_hold  = bus.in_data;
            m_phase = 1'b1;
          end else begin
            mq.push_back({m_hold, bus.in_data});
            m_phase = 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("m_a",        32'(bus.a),        32'(m_a));
      chk("m_b",        32'(bus.b),        32'(m_b));
      chk("m_out_valid",32'(bus.out_valid),32'(m_v));
      chk("m_count",    32'(count),        32'(mq.size()));
      chk("m_phase",    32'(phase),        32'(m_phase));
      chk("m_in_ready", 32'(bus.in_ready), 32'(!m_phase || (mq.size() < DEPTH)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pair(string nm, logic [7:0] ea, logic [7:0] eb);
    chk({nm, "_a"}, 32'(bus.a), 32'(ea));
    chk({nm, "_b"}, 32'(bus.b), 32'(eb));
    chk({nm, "_v"}, 32'(bus.out_valid), 32'(1));
  endtask

  task automatic chk_idle(string nm);
    chk({nm, "_a"}, 32'(bus.a), 32'(0));
    chk({nm, "_b"}, 32'(bus.b), 32'(0));
    chk({nm, "_v"}, 32'(bus.out_valid), 32'(0));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // Reset for two cycles
    step(); step();
    chk_idle("rst");
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_phase", 32'(phase), 32'(0));
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    reset = 1'b0;

    // Single pair, minimum latency, signed b
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'h05; step();
    bus.in_data = 8'hFD; step();
    bus.in_valid = 1'b0; step();
    chk_pair("lat", 8'h05, 8'hFD);
    chk("lat_b_signed", 32'($signed(bus.b)), 32'(-3));
    step();
    chk_idle("lat_after");

    // Fill to full with out_ready low, then drain in order
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(i + 1); step();
    end
    chk("full_count", 32'(count), 32'(4));
    chk("full_phase", 32'(phase), 32'(0));
    bus.in_data = 8'd9; step();
    chk("ninth_phase", 32'(phase), 32'(1));
    chk("ninth_in_ready", 32'(bus.in_ready), 32'(0));
    bus.in_data = 8'd10; step();
    chk("tenth_stall_count", 32'(count), 32'(4));
    chk("tenth_stall_phase", 32'(phase), 32'(1));
    bus.out_ready = 1'b1; step();
    chk_pair("drain0", 8'd1, 8'd2);
    chk("drain0_count", 32'(count), 32'(3));
    step();
    bus.in_valid = 1'b0;
    chk_pair("drain1", 8'd3, 8'd4);
    chk("drain1_count", 32'(count), 32'(3));
    chk("drain1_phase", 32'(phase), 32'(0));
    step(); chk_pair("drain2", 8'd5, 8'd6);
    step(); chk_pair("drain3", 8'd7, 8'd8);
    step(); chk_pair("drain4", 8'd9, 8'd10);
    step(); chk_idle("drain_end");
    chk("drain_end_count", 32'(count), 32'(0));

    // Simultaneous push and pop at count 2
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(11 + i); step();
    end
    chk("pp_pre_count", 32'(count), 32'(2));
    bus.out_ready = 1'b1; bus.in_data = 8'd16; step();
    bus.in_valid = 1'b0;
    chk("pp_count", 32'(count), 32'(2));
    chk_pair("pp0", 8'd11, 8'd12);
    step(); chk_pair("pp1", 8'd13, 8'd14);
    step(); chk_pair("pp2", 8'd15, 8'd16);
    step(); chk("pp_end_count", 32'(count), 32'(0));

    // Flush with phase 1, count 3 and a byte offered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'h30 + i); step();
    end
    chk("fl_pre_count", 32'(count), 32'(3));
    chk("fl_pre_phase", 32'(phase), 32'(1));
    flush = 1'b1; bus.out_ready = 1'b1; bus.in_data = 8'h55; step();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk_idle("fl");
    chk("fl_count", 32'(count), 32'(0));
    chk("fl_phase", 32'(phase), 32'(0));
    bus.in_valid = 1'b1; bus.in_data = 8'h21; step();
    bus.in_data = 8'h22; step();
    bus.in_valid = 1'b0; step();
    chk_pair("fl_next", 8'h21, 8'h22);

    // Sign extremes
    bus.in_valid = 1'b1; bus.in_data = 8'h80; step();
    step();
    bus.in_data = 8'h7F; step();
    chk("neg_a", 32'($signed(bus.a)), 32'(-128));
    chk("neg_b", 32'($signed(bus.b)), 32'(-128));
    chk("neg_v", 32'(bus.out_valid), 32'(1));
    step();
    bus.in_valid = 1'b0; step();
    chk("pos_a", 32'($signed(bus.a)), 32'(127));
    chk("pos_b", 32'($signed(bus.b)), 32'(127));

    // Mid-stream reset discards a partial pair and stored pairs
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'h40 + i); step();
    end
    reset = 1'b1; bus.in_data = 8'h4F; step();
    reset = 1'b0; bus.in_valid = 1'b0;
    chk("mrst_count", 32'(count), 32'(0));
    chk("mrst_phase", 32'(phase), 32'(0));
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'h61; step();
    bus.in_data = 8'h62; step();
    bus.in_valid = 1'b0; step();
    chk_pair("mrst_next", 8'h61, 8'h62);
    step();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
